// File: rtl/tick_period_monitor.sv
// Measures the clock cycles between rising edges of a periodic tick and classifies
// each period against EXP_PERIOD +/- TOL, tracking lock, timeout and error count.
module tick_period_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 21,
    parameter int TOL        = 0,
    parameter int LOCK_N     = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             ok,
    output logic             err,
    output logic             timeout,
    output logic             locked,
    output logic [7:0]       err_count
);

    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [RUN_W-1:0] LOCK_C  = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             tick_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             to_q, to_d;
    logic             locked_q, locked_d;
    logic [7:0]       ec_q, ec_d;

    logic             tick_rise;
    logic [CNT_W-1:0] dev;
    logic             in_tol;
    logic [RUN_W-1:0] run_inc;
    logic             ec_inc;

    assign tick_rise = tick & ~tick_q;
    // Absolute deviation taken by ordering the operands, so short periods never wrap.
    assign dev       = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
    assign in_tol    = (dev <= TOL_C);
    assign run_inc   = (run_q == LOCK_C) ? run_q : (run_q + RUN_ONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        period_d = period_q;
        pv_d     = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        locked_d = locked_q;
        ec_inc   = 1'b0;
        case (state_q)
            WAIT_FIRST: begin
                if (tick_rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = MEASURE;
                end
            end
            default: begin
                if (tick_rise) begin
                    cnt_d    = CNT_ONE;
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (in_tol) begin
                        ok_d  = 1'b1;
                        run_d = run_inc;
                        if (run_inc == LOCK_C) begin
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end
                    end else begin
                        err_d    = 1'b1;
                        run_d    = '0;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                        ec_inc   = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    to_d     = 1'b1;
                    locked_d = 1'b0;
                    run_d    = '0;
                    cnt_d    = '0;
                    ec_inc   = 1'b1;
                    state_d  = WAIT_FIRST;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase

        // A clear wins over a coincident error so the counter restarts from zero.
        if (clr_err) begin
            ec_d = 8'd0;
        end else if (ec_inc && (ec_q != 8'hFF)) begin
            ec_d = ec_q + 8'd1;
        end else begin
            ec_d = ec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_FIRST;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            run_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            locked_q <= 1'b0;
            ec_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            to_q     <= to_d;
            locked_q <= locked_d;
            ec_q     <= ec_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pv_q;
    assign ok           = ok_q;
    assign err          = err_q;
    assign timeout      = to_q;
    assign locked       = locked_q;
    assign err_count    = ec_q;

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor: expected events are queued when a tick is
// driven and compared, cycle-exact, when the DUT raises a pulse.
`timescale 1ns/1ps
module tb_tick_period_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       tick2 = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] per1, ec1, per2, ec2;
    logic       pv1, ok1, err1, to1, lk1;
    logic       pv2, ok2, err2, to2, lk2;

    tick_period_monitor u_dut (
        .clk(clk), .rst(rst), .tick(tick), .clr_err(clr_err),
        .period(per1), .period_valid(pv1), .ok(ok1), .err(err1),
        .timeout(to1), .locked(lk1), .err_count(ec1)
    );

    tick_period_monitor #(.TOL(2)) u_dut_tol2 (
        .clk(clk), .rst(rst), .tick(tick2), .clr_err(clr_err),
        .period(per2), .period_valid(pv2), .ok(ok2), .err(err2),
        .timeout(to2), .locked(lk2), .err_count(ec2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] per;
        logic       pv, ok, er, to, lk;
        logic [7:0] ec;
        int         id;
    } exp_t;

    exp_t       q1[$];
    exp_t       q2[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         nid = 0;
    int         last_edge = 0;
    logic [7:0] exp_ec = 8'd0;
    logic [7:0] exp_period = 8'd0;
    bit         sel = 1'b0;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic compare(input int unit, input exp_t e, input logic [7:0] per, input logic pv,
                           input logic okv, input logic er, input logic to, input logic lk,
                           input logic [7:0] ec);
        logic [55:0] obs, want;
        obs  = {cyc, per, pv, okv, er, to, lk, 3'b000, ec};
        want = {e.cyc, e.per, e.pv, e.ok, e.er, e.to, e.lk, 3'b000, e.ec};
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL dut%0d_ev%0d: got cyc=%0d per=%0d pv=%b ok=%b err=%b to=%b lk=%b ec=%0d, want cyc=%0d per=%0d pv=%b ok=%b err=%b to=%b lk=%b ec=%0d",
                   unit, e.id, cyc, per, pv, okv, er, to, lk, ec,
                   e.cyc, e.per, e.pv, e.ok, e.er, e.to, e.lk, e.ec);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (pv1 | ok1 | err1 | to1) begin
            vectors++;
            assert (q1.size() != 0) else begin
                miscompares++;
                $error("FAIL dut1_spurious: got pv=%b ok=%b err=%b to=%b at cyc=%0d, want no event", pv1, ok1, err1, to1, cyc);
            end
            if (q1.size() != 0) compare(1, q1.pop_front(), per1, pv1, ok1, err1, to1, lk1, ec1);
        end
    end

    always @(posedge clk) begin
        #1;
        if (pv2 | ok2 | err2 | to2) begin
            vectors++;
            assert (q2.size() != 0) else begin
                miscompares++;
                $error("FAIL dut2_spurious: got pv=%b ok=%b err=%b to=%b at cyc=%0d, want no event", pv2, ok2, err2, to2, cyc);
            end
            if (q2.size() != 0) compare(2, q2.pop_front(), per2, pv2, ok2, err2, to2, lk2, ec2);
        end
    end

    task automatic push(input exp_t e);
        if (sel) q2.push_back(e);
        else q1.push_back(e);
    endtask

    // Raise the tick p cycles after the previous rising edge, hold it hi cycles.
    task automatic tk(input int p, input int hi, input bit pv, input bit okv, input bit lk,
                      input bit clr = 1'b0);
        exp_t e;
        while (cyc < last_edge + p) @(negedge clk);
        if (sel) tick2 = 1'b1;
        else tick = 1'b1;
        clr_err = clr;
        last_edge = cyc;
        if (pv) begin
            exp_period = 8'(p);
            if (!okv) exp_ec = sat_inc(exp_ec);
            if (clr) exp_ec = 8'd0;
            e = '{cyc: last_edge + 1, per: exp_period, pv: 1'b1, ok: okv, er: !okv,
                  to: 1'b0, lk: lk, ec: exp_ec, id: nid++};
            push(e);
        end
        @(negedge clk);
        clr_err = 1'b0;
        repeat (hi - 1) @(negedge clk);
        tick = 1'b0;
        tick2 = 1'b0;
    endtask

    task automatic expect_timeout();
        exp_t e;
        exp_ec = sat_inc(exp_ec);
        e = '{cyc: last_edge + 64, per: exp_period, pv: 1'b0, ok: 1'b0, er: 1'b0,
              to: 1'b1, lk: 1'b0, ec: exp_ec, id: nid++};
        push(e);
    endtask

    task automatic chk_zero(input int step);
        logic [29:0] obs;
        obs = {per1, pv1, ok1, err1, to1, lk1, ec1, per2[0], pv2, lk2, ec2[0]};
        vectors++;
        assert (obs === 30'd0 && per2 === 8'd0 && ec2 === 8'd0) else begin
            miscompares++;
            $error("FAIL reset_state%0d: got per=%0d pv=%b ok=%b err=%b to=%b lk=%b ec=%0d per2=%0d ec2=%0d, want all zero",
                   step, per1, pv1, ok1, err1, to1, lk1, ec1, per2, ec2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, want summary before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero(0);
        rst = 1'b0;
        last_edge = cyc;

        // Nominal stream: first tick only arms, lock on the 4th ok.
        tk(2, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tk(21, 1, 1, 1, i >= 3);

        // One long interval breaks lock, then relock.
        tk(23, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) tk(21, 1, 1, 1, i == 3);

        // Tick stops: timeout, then re-arm without a period.
        expect_timeout();
        tk(70, 1, 0, 0, 0);
        tk(21, 1, 1, 1, 0);

        // Level input held high for 30 cycles: one edge only.
        tk(21, 30, 1, 1, 0);
        tk(40, 1, 1, 0, 0);

        // Repeated timeouts saturate err_count.
        expect_timeout();
        for (int i = 0; i < 259; i++) begin
            tk(70, 1, 0, 0, 0);
            expect_timeout();
        end

        // Clear coincident with an err.
        tk(70, 1, 0, 0, 0);
        tk(21, 1, 1, 1, 0);
        tk(23, 1, 1, 0, 0, 1'b1);

        // Reset mid-interval, tick already high in the first cycle afterwards.
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero(1);
        exp_ec = 8'd0;
        exp_period = 8'd0;
        tick = 1'b1;
        rst = 1'b0;
        last_edge = cyc;
        @(negedge clk);
        tick = 1'b0;
        tk(21, 1, 1, 1, 0);
        expect_timeout();
        repeat (70) @(negedge clk);

        // TOL=2 instance: tolerance boundaries on both sides.
        sel = 1'b1;
        exp_ec = 8'd0;
        exp_period = 8'd0;
        last_edge = cyc;
        tk(3, 1, 0, 0, 0);
        tk(21, 1, 1, 1, 0);
        tk(19, 1, 1, 1, 0);
        tk(23, 1, 1, 1, 0);
        tk(24, 1, 1, 0, 0);
        tk(18, 1, 1, 0, 0);
        tk(21, 1, 1, 1, 0);
        expect_timeout();
        repeat (70) @(negedge clk);

        vectors++;
        assert (q1.size() == 0 && q2.size() == 0) else begin
            miscompares++;
            $error("FAIL missing_events: got %0d/%0d expected events never seen, want 0/0", q1.size(), q2.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
